mag_cmp_serial: RTL and testbench
=================================

Name: mag_cmp_serial

Overview:
Parametrised, digit-serial magnitude comparator for WIDTH-bit operands.
- Scans DIGIT bits per clock, most significant digit first, and stops early at the first unequal digit.
- Supports unsigned and two's-complement signed compare.
- Keeps the 3-line cascade inputs and outputs of the existing 4-bit comparator, so results chain across wider words.
- Used wherever wide compares are needed but a single-cycle WIDTH-bit comparator will not meet timing or area.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT, otherwise elaboration error.
DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH.
NDIG, WIDTH/DIGIT, derived digit count; not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  request strobe; sampled only while idle.
a_in  input  WIDTH  operand A; captured on the accepted start.
b_in  input  WIDTH  operand B; captured on the accepted start.
signed_mode  input  1  1 = two's-complement compare; captured on the accepted start.
ia_lt_b  input  1  cascade less-than input; captured on the accepted start.
ia_eq_b  input  1  cascade equal input; captured on the accepted start.
ia_gt_b  input  1  cascade greater-than input; captured on the accepted start.
busy  output  1  high while scanning.
done  output  1  single-cycle pulse when a result is registered.
oa_lt_b  output  1  registered A<B result.
oa_eq_b  output  1  registered A==B result.
oa_gt_b  output  1  registered A>B result.

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- rst forces: state IDLE, busy=0, done=0, oa_lt_b=oa_eq_b=oa_gt_b=0, idx=0. Operand registers need no reset.
- States:
  - IDLE: busy=0. On start=1, capture a_in, b_in, signed_mode and the cascade inputs, set idx=NDIG-1, go to SCAN. Otherwise stay.
  - SCAN: busy=1. Each edge compares digit idx of A against digit idx of B.
- Digit compare:
  - Digit idx is bits [idx*DIGIT +: DIGIT], compared unsigned.
  - When signed_mode=1 and idx=NDIG-1, invert bit DIGIT-1 of both digits before comparing (sign-bit flip).
- SCAN transitions:
  - Digits differ: register lt/gt from the digit compare, eq=0, done=1 next cycle, go to IDLE.
  - Digits equal and idx=0: register the cascade result, done=1, go to IDLE.
  - Cascade result: eq=ia_eq; gt=~(ia_lt|ia_eq); lt=~(ia_gt|ia_eq), using the captured values. All-zero cascade therefore yields lt=gt=1, and illegal combinations pass through unchanged.
  - Digits equal and idx>0: idx decrements, stay in SCAN.
- Latency:
  - done is high in the cycle following the k-th edge after the accepting edge.
  - k = (NDIG - index of first differing digit), range 1..NDIG.
  - Fully equal operands take NDIG cycles.
- Output holding: the o* outputs change only at a decision edge and hold until the next decision or rst. done is exactly one cycle wide.
- Handshake edge cases:
  - start while busy is ignored; no queueing.
  - The done cycle is an IDLE cycle, so start asserted during done is accepted (back-to-back issue allowed).
- Reset mid-SCAN aborts immediately. No done is generated and outputs clear to 0.
- Input changes after capture have no effect on the operation in flight.

Decomposition:
- Package mag_cmp_pkg holds:
  - state enum (IDLE, SCAN);
  - typedef cmp_res_t {lt, eq, gt};
  - function cascade_res(lt, eq, gt) implementing the cascade rule.
- Sub-module mag_cmp_digit: combinational DIGIT-bit compare with inputs a, b, flip_msb and outputs lt, eq, gt. Instantiated once; the FSM muxes digit idx into it.

Test Plan (WIDTH=16, DIGIT=4):
1. a=0x1234, b=0x1234, ia_eq_b=1, others 0, unsigned -> done 4 cycles after accept; eq=1, lt=gt=0; busy high for exactly 4 cycles.
2. a=0x8000, b=0x7FFF, unsigned -> done after 1 cycle, gt=1. Same operands with signed_mode=1 -> done after 1 cycle, lt=1.
3. a=0x12A0, b=0x12B0, unsigned -> done after 3 cycles; lt=1, eq=gt=0.
4. a=b=0xFFFF: ia_gt_b=1 only -> gt=1; all cascade inputs 0 -> lt=gt=1, eq=0; ia_lt_b=ia_gt_b=1 -> lt=gt=0.
5. Start a=0x0000, b=0x0001; assert rst after 2 SCAN cycles -> no done, outputs 0, busy=0. Then start while busy is ignored, and start during done launches the next compare with correct result and latency.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared types and the cascade rule for the digit-serial magnitude comparator.
package mag_cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    // Illegal cascade combinations pass straight through this rule.
    function automatic cmp_res_t cascade_res(
        input logic lt,
        input logic eq,
        input logic gt
    );
        cmp_res_t r;
        r.eq = eq;
        r.gt = ~(lt | eq);
        r.lt = ~(gt | eq);
        return r;
    endfunction

endpackage

// File: rtl/mag_cmp_digit.sv
// Combinational DIGIT-bit unsigned compare with optional sign-bit flip.
module mag_cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             flip_msb,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [DIGIT-1:0] msk;
    logic [DIGIT-1:0] ax;
    logic [DIGIT-1:0] bx;

    assign msk = flip_msb ? (DIGIT'(1) << (DIGIT - 1)) : '0;
    assign ax  = a ^ msk;
    assign bx  = b ^ msk;

    assign lt = ax < bx;
    assign eq = ax == bx;
    assign gt = ax > bx;

endmodule

// File: rtl/mag_cmp_serial.sv
// Digit-serial magnitude comparator, MS digit first, early exit on mismatch,
// with 4-bit-comparator style cascade inputs and outputs.
module mag_cmp_serial
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             signed_mode,
    input  logic             ia_lt_b,
    input  logic             ia_eq_b,
    input  logic             ia_gt_b,
    output logic             busy,
    output logic             done,
    output logic             oa_lt_b,
    output logic             oa_eq_b,
    output logic             oa_gt_b
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("mag_cmp_serial: WIDTH must be a multiple of DIGIT");
    end

    state_e           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    cmp_res_t         casc_q;
    cmp_res_t         res_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             flip;
    logic             d_lt;
    logic             d_eq;
    logic             d_gt;

    assign accept = (state_q == IDLE) && start;
    assign a_dig  = a_q[idx_q*DIGIT +: DIGIT];
    assign b_dig  = b_q[idx_q*DIGIT +: DIGIT];
    assign flip   = sgn_q && (idx_q == LAST);

    mag_cmp_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a       (a_dig),
        .b       (b_dig),
        .flip_msb(flip),
        .lt      (d_lt),
        .eq      (d_eq),
        .gt      (d_gt)
    );

    // Operand capture carries no reset so it stays a plain enable flop.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= a_in;
            b_q    <= b_in;
            sgn_q  <= signed_mode;
            casc_q <= {ia_lt_b, ia_eq_b, ia_gt_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= LAST;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!d_eq) begin
                        res_q   <= '{lt: d_lt, eq: 1'b0, gt: d_gt};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (idx_q == '0) begin
                        res_q   <= cascade_res(casc_q.lt, casc_q.eq, casc_q.gt);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign oa_lt_b = res_q.lt;
    assign oa_eq_b = res_q.eq;
    assign oa_gt_b = res_q.gt;

endmodule

// File: tb/tb_mag_cmp_serial.sv
// Self-checking bench: arithmetic reference model with per-cycle compare,
// directed literal cases and randomized traffic.
module tb_mag_cmp_serial;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             signed_mode;
    logic             ia_lt_b;
    logic             ia_eq_b;
    logic             ia_gt_b;
    logic             busy;
    logic             done;
    logic             oa_lt_b;
    logic             oa_eq_b;
    logic             oa_gt_b;

    int total = 0;
    int bad   = 0;

    mag_cmp_serial #(
        .WIDTH(WIDTH),
        .DIGIT(DIGIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .signed_mode(signed_mode),
        .ia_lt_b    (ia_lt_b),
        .ia_eq_b    (ia_eq_b),
        .ia_gt_b    (ia_gt_b),
        .busy       (busy),
        .done       (done),
        .oa_lt_b    (oa_lt_b),
        .oa_eq_b    (oa_eq_b),
        .oa_gt_b    (oa_gt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycles to decision: counted from the most significant differing digit.
    function automatic int ref_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int m;
        m = (1 << DIGIT) - 1;
        for (int d = NDIG - 1; d >= 0; d--) begin
            if (((int'(a) >> (d * DIGIT)) & m) != ((int'(b) >> (d * DIGIT)) & m))
                return NDIG - d;
        end
        return NDIG;
    endfunction

    // Result as {lt, eq, gt}.
    function automatic logic [2:0] ref_res(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic sgn,
        input logic il,
        input logic ie,
        input logic ig
    );
        logic lt;
        if (a != b) begin
            lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
            return {lt, 1'b0, ~lt};
        end
        return {~(ig | ie), ie, ~(il | ie)};
    endfunction

    logic       m_busy;
    logic       m_done;
    logic [2:0] m_out;
    logic [2:0] m_pend;
    int         m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= 3'b000;
            m_pend <= 3'b000;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_cnt  <= ref_lat(a_in, b_in);
                    m_pend <= ref_res(a_in, b_in, signed_mode, ia_lt_b, ia_eq_b, ia_gt_b);
                end
            end else if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_out  <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", 32'(busy), 32'(m_busy));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_res", 32'({oa_lt_b, oa_eq_b, oa_gt_b}), 32'(m_out));
    end

    task automatic scramble();
        a_in        = 16'($urandom);
        b_in        = 16'($urandom);
        signed_mode = 1'($urandom);
        {ia_lt_b, ia_eq_b, ia_gt_b} = 3'($urandom);
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(
        input string          nm,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic           sgn,
        input logic [2:0]     casc,
        input logic [2:0]     exp_res,
        input int             exp_lat,
        input bit             poke
    );
        int cyc;
        int bcnt;
        a_in        = a;
        b_in        = b;
        signed_mode = sgn;
        {ia_lt_b, ia_eq_b, ia_gt_b} = casc;
        start       = 1'b1;
        @(negedge clk);
        scramble();
        start = poke;
        cyc   = 0;
        bcnt  = 0;
        while (!done && cyc < 2 * NDIG + 4) begin
            if (busy) bcnt++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk({nm, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_res"}, 32'({oa_lt_b, oa_eq_b, oa_gt_b}), 32'(exp_res));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        a_in        = '0;
        b_in        = '0;
        signed_mode = 1'b0;
        {ia_lt_b, ia_eq_b, ia_gt_b} = 3'b000;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_res", 32'({oa_lt_b, oa_eq_b, oa_gt_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("equal", 16'h1234, 16'h1234, 1'b0, 3'b010, 3'b010, 4, 1'b0);
        run_op("uns_msd", 16'h8000, 16'h7FFF, 1'b0, 3'b000, 3'b001, 1, 1'b1);
        run_op("sgn_msd", 16'h8000, 16'h7FFF, 1'b1, 3'b000, 3'b100, 1, 1'b1);
        run_op("third_dig", 16'h12A0, 16'h12B0, 1'b0, 3'b010, 3'b100, 3, 1'b0);
        run_op("casc_gt", 16'hFFFF, 16'hFFFF, 1'b0, 3'b001, 3'b001, 4, 1'b1);
        run_op("casc_zero", 16'hFFFF, 16'hFFFF, 1'b0, 3'b000, 3'b101, 4, 1'b0);
        run_op("casc_ltgt", 16'hFFFF, 16'hFFFF, 1'b1, 3'b101, 3'b000, 4, 1'b0);
        run_op("sgn_neg", 16'hFFF0, 16'h0010, 1'b1, 3'b000, 3'b100, 1, 1'b0);

        a_in  = 16'h0000;
        b_in  = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_res", 32'({oa_lt_b, oa_eq_b, oa_gt_b}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end

        run_op("after_abort", 16'h0000, 16'h0001, 1'b0, 3'b000, 3'b100, 4, 1'b1);
        run_op("b2b", 16'h5A00, 16'h5900, 1'b0, 3'b000, 3'b001, 2, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            a_in = 16'($urandom);
            case ($urandom % 4)
                0:       b_in = a_in;
                1:       b_in = a_in ^ (16'(1) << ($urandom % WIDTH));
                default: b_in = 16'($urandom);
            endcase
            signed_mode = 1'($urandom);
            {ia_lt_b, ia_eq_b, ia_gt_b} = 3'($urandom);
            start = ($urandom % 3) == 0;
            rst   = ($urandom % 400) == 0;
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2 * NDIG + 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
